gf180mcu_fd_sc_mcu9t5v0__scan_ctrl: RTL

Scan-chain controller: the driving end of the mux-D scan protocol used by the library's scan flops (SE/SI in, Q as scan-out). It loads a test pattern into a chain of CHAIN_LEN scan flops, then drops SE for a capture window. It then shifts the captured response out, compares it against an expected vector, and reports completion. It sits beside a chain of sdffq cells in test logic, clocked by the same CLK as the chain.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__scan_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__scan_ctrl
// Brief   : Mux-D scan-chain driver: load pattern, capture, unload, compare.
// Revision: 1.0
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__scan_ctrl #(
  parameter int CHAIN_LEN   = 8,
  parameter int CAPTURE_CYC = 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 MISMATCH
);

  localparam int c_CW = $clog2(CHAIN_LEN + 1);
  localparam logic [c_CW-1:0] c_SHIFT_LAST = c_CW'(CHAIN_LEN - 1);
  localparam logic [c_CW-1:0] c_CAP_LAST   = c_CW'(CAPTURE_CYC - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_SHIFT_IN  = 3'd1;
  localparam logic [2:0] c_CAPTURE   = 3'd2;
  localparam logic [2:0] c_SHIFT_OUT = 3'd3;
  localparam logic [2:0] c_FIN       = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [c_CW-1:0]      r_cnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-2:0] r_sr;
  logic [CHAIN_LEN-1:0] w_sr_next;
  logic                 r_se;
  logic                 r_si;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_mis;
  logic                 w_last_shift;
  logic                 w_last_cap;

  assign w_last_shift = (r_cnt == c_SHIFT_LAST);
  assign w_last_cap   = (r_cnt == c_CAP_LAST);
  // Pre-edge SO completes the response word, MSB first.
  assign w_sr_next    = {r_sr, SO};

  always_ff @(posedge CLK) begin
    if (!RN) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_FIN: w_next = START ? c_SHIFT_IN : c_IDLE;
      c_SHIFT_IN:    if (w_last_shift) w_next = c_CAPTURE;
      c_CAPTURE:     if (w_last_cap)   w_next = c_SHIFT_OUT;
      c_SHIFT_OUT:   if (w_last_shift) w_next = c_FIN;
      default:       w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_cnt  <= '0;
      r_pat  <= '0;
      r_exp  <= '0;
      r_sr   <= '0;
      r_se   <= 1'b0;
      r_si   <= 1'b0;
      r_resp <= '0;
      r_mis  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_FIN: begin
          r_se <= 1'b0;
          r_si <= 1'b0;
          if (START) begin
            // r_pat keeps the bits still to be presented, next one at the MSB.
            r_pat <= {PAT_IN[CHAIN_LEN-2:0], 1'b0};
            r_exp <= EXP_IN;
            r_cnt <= '0;
            r_se  <= 1'b1;
            r_si  <= PAT_IN[CHAIN_LEN-1];
            r_mis <= 1'b0;
          end
        end
        c_SHIFT_IN: begin
          if (w_last_shift) begin
            r_se  <= 1'b0;
            r_si  <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_si  <= r_pat[CHAIN_LEN-1];
            r_pat <= {r_pat[CHAIN_LEN-2:0], 1'b0};
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_CAPTURE: begin
          if (w_last_cap) begin
            r_se  <= 1'b1;
            r_si  <= 1'b0;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_SHIFT_OUT: begin
          r_sr <= w_sr_next[CHAIN_LEN-2:0];
          if (w_last_shift) begin
            r_se   <= 1'b0;
            r_resp <= w_sr_next;
            r_mis  <= (w_sr_next != r_exp);
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_se <= 1'b0;
          r_si <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    BUSY = (r_state == c_SHIFT_IN) || (r_state == c_CAPTURE) ||
           (r_state == c_SHIFT_OUT);
    DONE = (r_state == c_FIN);
  end

  assign SE       = r_se;
  assign SI       = r_si;
  assign RESP     = r_resp;
  assign MISMATCH = r_mis;

endmodule
`default_nettype wire
